controler_cursa: RTL



---
 rtl/cursa_pkg.sv | 40 ++++
 rtl/detector_finish.sv | 63 ++++++
 rtl/controler_cursa.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cursa_pkg.sv
// rtl/cursa_pkg.sv - shared encodings and ramp table for the run sequencer
package cursa_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAMP     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_LOST     = 3'd3;
  localparam logic [2:0] ST_FINISHED = 3'd4;

  // Motor driver direction codes
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b00;

  // Circuit selector codes
  localparam logic [1:0] CIRC_CLEAR     = 2'b00;
  localparam logic [1:0] CIRC_STRAIGHT  = 2'b01;
  localparam logic [1:0] CIRC_CURVES    = 2'b10;
  localparam logic [1:0] CIRC_ENDURANCE = 2'b11;

  // Remembered side of the line
  localparam logic [1:0] SIDE_NONE  = 2'b00;
  localparam logic [1:0] SIDE_RIGHT = 2'b10;
  localparam logic [1:0] SIDE_LEFT  = 2'b01;

  localparam logic [11:0] DUTY_OFF = 12'h000;
  localparam logic [11:0] DUTY_MAX = 12'h999;

  // BCD duty for each soft-start step
  function automatic logic [11:0] ramp_duty(input logic [1:0] idx);
    case (idx)
      2'd0:    ramp_duty = 12'h250;
      2'd1:    ramp_duty = 12'h500;
      2'd2:    ramp_duty = 12'h750;
      default: ramp_duty = 12'h999;
    endcase
  endfunction

endpackage

// File: rtl/detector_finish.sv
// rtl/detector_finish.sv - finish-line debounce with re-arm, one-cycle lap pulse
module detector_finish
  #(
    parameter logic [15:0] DEB_CYCLES   = 16'd5000,
    parameter logic [15:0] REARM_CYCLES = 16'd50000
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic senzor_1,
    input  logic senzor_5,
    output logic lap
  );

  logic        armed;
  logic [15:0] deb_cnt;
  logic [15:0] rearm_cnt;
  logic        both_high;
  logic        both_low;

  assign both_high = senzor_1 & senzor_5;
  assign both_low  = ~senzor_1 & ~senzor_5;

  // While armed, count consecutive marker cycles; after a lap wait for a clean gap before re-arming
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      armed     <= 1'b1;
      deb_cnt   <= 16'd0;
      rearm_cnt <= 16'd0;
      lap       <= 1'b0;
    end else begin
      lap <= 1'b0;
      if (armed) begin
        rearm_cnt <= 16'd0;
        if (both_high) begin
          if (deb_cnt == DEB_CYCLES - 16'd1) begin
            lap     <= 1'b1;
            armed   <= 1'b0;
            deb_cnt <= 16'd0;
          end else begin
            deb_cnt <= deb_cnt + 16'd1;
          end
        end else begin
          deb_cnt <= 16'd0;
        end
      end else begin
        deb_cnt <= 16'd0;
        if (both_low) begin
          if (rearm_cnt == REARM_CYCLES - 16'd1) begin
            armed     <= 1'b1;
            rearm_cnt <= 16'd0;
          end else begin
            rearm_cnt <= rearm_cnt + 16'd1;
          end
        end else begin
          rearm_cnt <= 16'd0;
        end
      end
    end
  end

endmodule

// File: rtl/controler_cursa.sv
// rtl/controler_cursa.sv - line-follower run sequencer with registered motor outputs
module controler_cursa
  import cursa_pkg::*;
  #(
    parameter logic [15:0] DEB_CYCLES   = 16'd5000,
    parameter logic [15:0] REARM_CYCLES = 16'd50000,
    parameter logic [19:0] RAMP_CYCLES  = 20'd250000,
    parameter logic [23:0] LOST_TIMEOUT = 24'd5000000,
    parameter logic [7:0]  LAPS_CURBE   = 8'd10
  )
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        senzor_1,
    input  logic        senzor_2,
    input  logic        senzor_3,
    input  logic        senzor_4,
    input  logic        senzor_5,
    input  logic [1:0]  circuit,
    output logic [1:0]  directie_driverA,
    output logic [1:0]  directie_driverB,
    output logic [11:0] factor_dc_driverA,
    output logic [11:0] factor_dc_driverB,
    output logic [7:0]  count_ture,
    output logic        stop,
    output logic        fault,
    output logic        semnal_dreapta,
    output logic        semnal_stanga
  );

  logic [2:0]  state, state_n;
  logic [1:0]  ramp_idx, ramp_idx_n;
  logic [19:0] ramp_cnt, ramp_cnt_n;
  logic [23:0] lost_cnt, lost_cnt_n;
  logic [1:0]  side, side_n;
  logic [7:0]  count_n;
  logic        fault_n;
  logic        start_q;
  logic        start_rise;
  logic        active;
  logic        lap;
  logic        lap_stop;
  logic        line_seen;
  logic [1:0]  dir_a_n, dir_b_n;
  logic [11:0] duty_n;
  logic        stop_n;

  assign start_rise = start & ~start_q;
  assign active     = (state == ST_RAMP) || (state == ST_RUN) || (state == ST_LOST);
  assign line_seen  = senzor_2 | senzor_3 | senzor_4;
  assign lap_stop   = ((circuit == CIRC_STRAIGHT) && (count_ture >= 8'd1)) ||
                      ((circuit == CIRC_CURVES)   && (count_ture >= LAPS_CURBE));

  detector_finish #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REARM_CYCLES (REARM_CYCLES)
  ) u_detector_finish (
    .clk      (clk),
    .rst      (rst),
    .enable   (active),
    .senzor_1 (senzor_1),
    .senzor_5 (senzor_5),
    .lap      (lap)
  );

  // Next state, counters and the outputs that belong to the state being entered
  always_comb begin
    state_n    = state;
    ramp_idx_n = ramp_idx;
    ramp_cnt_n = ramp_cnt;
    lost_cnt_n = lost_cnt;
    side_n     = side;
    count_n    = count_ture;
    fault_n    = fault;

    if (active) begin
      if (lap && (count_ture != 8'hFF)) count_n = count_ture + 8'd1;
      if (senzor_2)      side_n = SIDE_RIGHT;
      else if (senzor_4) side_n = SIDE_LEFT;
    end

    case (state)
      ST_IDLE: begin
        side_n = SIDE_NONE;
        if (start_rise && (circuit != CIRC_CLEAR)) begin
          state_n    = ST_RAMP;
          ramp_idx_n = 2'd0;
          ramp_cnt_n = 20'd0;
        end
      end
      ST_RAMP: begin
        if (lap_stop) begin
          state_n = ST_FINISHED;
        end else if (ramp_cnt == RAMP_CYCLES - 20'd1) begin
          ramp_cnt_n = 20'd0;
          if (ramp_idx == 2'd3) state_n = ST_RUN;
          else                  ramp_idx_n = ramp_idx + 2'd1;
        end else begin
          ramp_cnt_n = ramp_cnt + 20'd1;
        end
      end
      ST_RUN: begin
        if (lap_stop) begin
          state_n = ST_FINISHED;
        end else if (!line_seen) begin
          state_n    = ST_LOST;
          lost_cnt_n = 24'd0;
        end
      end
      ST_LOST: begin
        if (lap_stop) begin
          state_n = ST_FINISHED;
        end else if (line_seen) begin
          state_n    = ST_RUN;
          lost_cnt_n = 24'd0;
        end else if (lost_cnt == LOST_TIMEOUT - 24'd1) begin
          state_n    = ST_FINISHED;
          fault_n    = 1'b1;
          lost_cnt_n = 24'd0;
        end else begin
          lost_cnt_n = lost_cnt + 24'd1;
        end
      end
      ST_FINISHED: state_n = ST_FINISHED;
      default:     state_n = ST_IDLE;
    endcase

    // Selecting the clear circuit abandons any run and wipes the lap history
    if (circuit == CIRC_CLEAR) begin
      state_n = ST_IDLE;
      count_n = 8'd0;
      fault_n = 1'b0;
    end

    dir_a_n = DIR_BRAKE;
    dir_b_n = DIR_BRAKE;
    duty_n  = DUTY_OFF;
    stop_n  = 1'b1;
    case (state_n)
      ST_RAMP, ST_RUN: begin
        dir_a_n = senzor_2 ? DIR_REV : DIR_FWD;
        dir_b_n = senzor_4 ? DIR_REV : DIR_FWD;
        duty_n  = (state_n == ST_RAMP) ? ramp_duty(ramp_idx_n) : DUTY_MAX;
        stop_n  = ~senzor_3;
      end
      ST_LOST: begin
        case (side_n)
          SIDE_RIGHT: begin dir_a_n = DIR_REV; dir_b_n = DIR_FWD; end
          SIDE_LEFT:  begin dir_a_n = DIR_FWD; dir_b_n = DIR_REV; end
          default:    begin dir_a_n = DIR_REV; dir_b_n = DIR_REV; end
        endcase
        duty_n = DUTY_MAX;
        stop_n = ~senzor_3;
      end
      default: begin
        dir_a_n = DIR_BRAKE;
        dir_b_n = DIR_BRAKE;
        duty_n  = DUTY_OFF;
        stop_n  = 1'b1;
      end
    endcase
  end

  // Register state and every output so the drivers never see combinational glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      ramp_idx          <= 2'd0;
      ramp_cnt          <= 20'd0;
      lost_cnt          <= 24'd0;
      side              <= SIDE_NONE;
      start_q           <= 1'b0;
      count_ture        <= 8'd0;
      fault             <= 1'b0;
      stop              <= 1'b1;
      directie_driverA  <= DIR_BRAKE;
      directie_driverB  <= DIR_BRAKE;
      factor_dc_driverA <= DUTY_OFF;
      factor_dc_driverB <= DUTY_OFF;
      semnal_dreapta    <= 1'b0;
      semnal_stanga     <= 1'b0;
    end else begin
      state             <= state_n;
      ramp_idx          <= ramp_idx_n;
      ramp_cnt          <= ramp_cnt_n;
      lost_cnt          <= lost_cnt_n;
      side              <= side_n;
      start_q           <= start;
      count_ture        <= count_n;
      fault             <= fault_n;
      stop              <= stop_n;
      directie_driverA  <= dir_a_n;
      directie_driverB  <= dir_b_n;
      factor_dc_driverA <= duty_n;
      factor_dc_driverB <= duty_n;
      semnal_dreapta    <= senzor_1;
      semnal_stanga     <= senzor_5;
    end
  end

endmodule
